// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync inputs and recovered timing outputs of the VGA sync decoder
interface vga_sync_decoder_if;
   logic        h_sync_in;
   logic        v_sync_in;
   logic [10:0] x_location;
   logic [10:0] y_location;
   logic        display_enable;
   logic        locked;
   logic        frame_start;
   logic        sync_error;
   modport master (
      output h_sync_in, v_sync_in,
      input  x_location, y_location, display_enable, locked, frame_start, sync_error
   );
   modport slave (
      input  h_sync_in, v_sync_in,
      output x_location, y_location, display_enable, locked, frame_start, sync_error
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and active video from hsync/vsync and tracks timing lock
module vga_sync_decoder #(
   parameter int H_RES         = 1280,
   parameter int H_FRONT_PORCH = 48,
   parameter int H_SYNC_PULSE  = 112,
   parameter int H_BACK_PORCH  = 248,
   parameter int V_RES         = 1024,
   parameter int V_FRONT_PORCH = 1,
   parameter int V_SYNC_PULSE  = 3,
   parameter int V_BACK_PORCH  = 38
) (
   input logic               clk,
   input logic               rst,
   vga_sync_decoder_if.slave bus
);
   localparam int H_TOTAL = H_RES + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL = V_RES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam logic [11:0] HT  = 12'(H_TOTAL);
   localparam logic [11:0] HTO = 12'(2 * H_TOTAL);
   localparam logic [10:0] VT  = 11'(V_TOTAL);
   localparam logic [10:0] XL  = 11'(H_RES + H_FRONT_PORCH);
   localparam logic [10:0] XM  = 11'(H_TOTAL - 1);
   localparam logic [10:0] YL  = 11'(V_RES + V_FRONT_PORCH - 1);
   localparam logic [10:0] YM  = 11'(V_TOTAL - 1);
   localparam logic [10:0] HR  = 11'(H_RES);
   localparam logic [10:0] VR  = 11'(V_RES);

   typedef enum logic [1:0] {UNLOCKED, H_LOCKED, LOCKED} state_t;

   state_t      state, state_n;
   logic        h_q, v_q, h_seen, v_seen, good, good_n, err_n;
   logic [10:0] x, y, v_lines, v_base;
   logic [11:0] h_period;
   logic        locked, display_enable, frame_start, sync_error;

   wire h_edge  = bus.h_sync_in & ~h_q;
   wire v_edge  = bus.v_sync_in & ~v_q;
   wire x_wrap  = x == XM;
   wire h_eval  = h_edge & h_seen;
   wire v_eval  = v_edge & v_seen;
   wire h_good  = h_period == HT;
   wire v_good  = v_lines == VT;
   wire timeout = h_period == HTO;
   wire h_bad   = (h_eval & ~h_good) | timeout;

   assign v_base = v_edge ? 11'd0 : v_lines;

   always_comb begin
      state_n = state;
      good_n  = good;
      err_n   = 1'b0;
      case (state)
         UNLOCKED: begin
            if (timeout) begin
               good_n = 1'b0;
               err_n  = 1'b1;
            end else if (h_eval) begin
               good_n  = h_good & ~good;
               state_n = (h_good & good) ? H_LOCKED : UNLOCKED;
            end
         end
         default: begin
            good_n = 1'b0;
            if (h_bad) begin
               state_n = UNLOCKED;
               err_n   = 1'b1;
            end else if (v_eval) begin
               err_n   = ~v_good;
               state_n = v_good ? LOCKED : (state == LOCKED ? UNLOCKED : H_LOCKED);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q            <= 1'b0;
         v_q            <= 1'b0;
         h_seen         <= 1'b0;
         v_seen         <= 1'b0;
         x              <= '0;
         y              <= '0;
         h_period       <= '0;
         v_lines        <= '0;
         good           <= 1'b0;
         state          <= UNLOCKED;
         locked         <= 1'b0;
         sync_error     <= 1'b0;
         display_enable <= 1'b0;
         frame_start    <= 1'b0;
      end else begin
         h_q            <= bus.h_sync_in;
         v_q            <= bus.v_sync_in;
         h_seen         <= h_seen | h_edge;
         v_seen         <= v_seen | v_edge;
         x              <= h_edge ? XL : (x_wrap ? 11'd0 : x + 11'd1);
         y              <= v_edge ? YL : ((x_wrap & ~h_edge) ? (y == YM ? 11'd0 : y + 11'd1) : y);
         h_period       <= h_edge ? 12'd1 : (h_period == 12'hfff ? h_period : h_period + 12'd1);
         // a coincident h_edge counts as the first line of the new frame
         v_lines        <= v_base + 11'(h_edge && v_base != 11'h7ff);
         good           <= good_n;
         state          <= state_n;
         locked         <= state_n == LOCKED;
         sync_error     <= err_n;
         display_enable <= locked & (x < HR) & (y < VR);
         frame_start    <= locked & (x == 11'd0) & (y == 11'd0);
      end
   end

   assign bus.x_location     = x;
   assign bus.y_location     = y;
   assign bus.locked         = locked;
   assign bus.sync_error     = sync_error;
   assign bus.display_enable = display_enable;
   assign bus.frame_start    = frame_start;
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- H_RES, 1280, active pixels per line
- H_FRONT_PORCH, 48, pixels between active video and hsync
- H_SYNC_PULSE, 112, hsync width in pixels
- H_BACK_PORCH, 248, pixels between hsync and active video
- V_RES, 1024, active lines per frame
- V_FRONT_PORCH, 1, lines between active video and vsync
- V_SYNC_PULSE, 3, vsync width in lines
- V_BACK_PORCH, 38, lines between vsync and active video
REQ-002 SHALL define derived constants:
- H_TOTAL = sum of the four H terms (1688)
- V_TOTAL = sum of the four V terms (1066)
REQ-003 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, pixel clock; single clock domain
- rst, in, 1, synchronous, active-high reset
- h_sync_in, in, 1, active-high hsync, synchronous to clk
- v_sync_in, in, 1, active-high vsync, synchronous to clk
- x_location, out, 11, recovered pixel column
- y_location, out, 11, recovered line
- display_enable, out, 1, recovered active-video flag
- locked, out, 1, timing matches parameters
- frame_start, out, 1, one-cycle pulse at pixel (0,0)
- sync_error, out, 1, one-cycle pulse on period mismatch or hsync timeout

Function
REQ-004 SHALL register h_sync_in/v_sync_in into h_q/v_q each cycle:
- h_edge = h_sync_in & ~h_q
- v_edge = v_sync_in & ~v_q
REQ-005 x_location SHALL update as follows:
- on h_edge: load H_RES+H_FRONT_PORCH (1328)
- else at H_TOTAL-1: wrap to 0
- else: increment by 1
- h_edge SHALL win over wrap when both occur.
REQ-006 y_location SHALL update as follows:
- on v_edge: load V_RES+V_FRONT_PORCH-1 (1024)
- else when x_location wraps H_TOTAL-1 -> 0: increment, wrapping V_TOTAL-1 -> 0
- v_edge SHALL win over increment when both occur.
REQ-007 x/y SHALL track free-running in every lock state; they are meaningful only while locked=1.
REQ-008 h_period (12-bit, saturating at 4095) SHALL work as follows:
- load 1 on h_edge, else increment
- at h_edge, measured line length = h_period value before reload
- first h_edge after reset sets h_seen and SHALL NOT be evaluated
REQ-009 v_lines (11-bit, saturating at 2047) SHALL work as follows:
- load 0 on v_edge; increment on each h_edge
- at v_edge, measured frame length = v_lines value before reload
- first v_edge after reset sets v_seen and SHALL NOT be evaluated
REQ-010 lock FSM states: UNLOCKED, H_LOCKED, LOCKED. A good line is an evaluated h_edge with measured length == H_TOTAL.
REQ-011 UNLOCKED -> H_LOCKED SHALL occur after 2 consecutive good lines; a bad line resets the good-line count to 0.
REQ-012 H_LOCKED -> LOCKED SHALL occur on an evaluated v_edge with frame length == V_TOTAL. A frame-length mismatch in H_LOCKED SHALL keep the state and pulse sync_error.
REQ-013 H_LOCKED or LOCKED -> UNLOCKED SHALL occur on any of:
- evaluated h_edge with length != H_TOTAL
- h_period reaching 2*H_TOTAL (3376), i.e. hsync timeout
- in LOCKED only: evaluated v_edge with frame length != V_TOTAL
Each SHALL pulse sync_error for exactly one cycle. In UNLOCKED, a timeout pulses sync_error once per saturation event, not every cycle.
REQ-014 Transitions SHALL take effect on the clock edge that samples the qualifying event. locked = (state == LOCKED), registered.
REQ-015 display_enable SHALL be registered = locked & (x_location < H_RES) & (y_location < V_RES), one cycle after the x/y values it reflects.
REQ-016 frame_start SHALL pulse one cycle when locked and x_location, y_location transition to (0,0), registered like display_enable.
REQ-017 Simultaneous h_edge and v_edge SHALL apply both updates in the same cycle, with v_lines evaluated before the increment.

Reset
REQ-018 While rst=1 at a clk edge:
- x_location, y_location, h_period, v_lines cleared to 0
- h_q, v_q, h_seen, v_seen, good-line count cleared to 0
- display_enable, locked, frame_start, sync_error cleared to 0
- state set to UNLOCKED
REQ-019 An input held high through reset release SHALL register as an edge on the first post-reset cycle; that edge is treated as the first, unevaluated edge.
REQ-020 Reset asserted mid-frame SHALL drop locked in the same cycle; relock SHALL require the full REQ-011/REQ-012 sequence.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Reset: rst=1 for 3 cycles with sync inputs toggling -> all outputs 0; after release, locked=0.
- Hsync edges every 1688 cycles: after the 3rd edge, state is H_LOCKED; x_location=1328 one cycle after each edge; locked stays 0.
- Nominal stream, two vsync edges 1066 lines apart: locked=1 after the 2nd vsync edge; display_enable high for exactly 1280x1024 cycles per frame; frame_start once every 1799408 cycles.
- While locked, one line of 1687 cycles: sync_error pulses one cycle, locked=0 the following cycle, then relock after 2 good lines plus 1 good frame.
- While locked, hsync held low: at h_period=3376, sync_error pulses once and locked drops; no further sync_error while held low.
- Coincident h_edge, x wrap and v_edge in one cycle: next cycle x_location=1328 and y_location=1024.
